sdram_arbiter: RTL

Round-robin arbiter that shares the single command port of the SDRAM controller core among `N_PORTS` independent requesters (CPU, video fetch, DMA, etc.). It sits between the requesters and the core's control-side port. It grants one requester at a time, forwards that requester's read or write, and routes the completion back to it. A watchdog ends any transaction whose completion never arrives.

---
 rtl/sdram_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of the SDRAM core command port with completion routing and watchdog
module sdram_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 25,
  parameter int WORD_LEN   = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_PORTS-1:0]               port_rd,
  input  logic [N_PORTS*WORD_LEN-1:0]      port_wr,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]    port_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0]    port_write_data,
  output logic [N_PORTS-1:0]               port_rvalid,
  output logic [N_PORTS-1:0]               port_wvalid,
  output logic [N_PORTS-1:0]               port_error,
  output logic [DATA_WIDTH-1:0]            port_read_data,
  output logic [$clog2(N_PORTS)-1:0]       grant,
  output logic                             mem_rd,
  output logic [WORD_LEN-1:0]              mem_wr,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_write_data,
  input  logic                             mem_rdy,
  input  logic                             mem_rvalid,
  input  logic                             mem_wvalid,
  input  logic                             mem_error,
  input  logic [DATA_WIDTH-1:0]            mem_read_data
);
  localparam int GW = $clog2(N_PORTS);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  logic [1:0] state;
  logic [GW-1:0] ptr, next_idx, nxt_ptr;
  logic [GW:0] cand;
  logic found;
  logic [15:0] wdog;
  logic [N_PORTS-1:0] req, sel;
  logic g_rd, g_req, in_wait, done, tmo;
  logic [WORD_LEN-1:0] g_wr;
  // a port requests when it reads or has any write strobe set
  always_comb begin
    req = '0;
    for (int i = 0; i < N_PORTS; i++) req[i] = port_rd[i] | (|port_wr[i*WORD_LEN +: WORD_LEN]);
  end
  // first requesting port at or after ptr, wrapping; descending loop so the nearest one wins
  always_comb begin
    found = 1'b0;
    next_idx = ptr;
    cand = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_PORTS)) cand = cand - (GW+1)'(N_PORTS);
      if (req[cand[GW-1:0]]) begin
        found = 1'b1;
        next_idx = cand[GW-1:0];
      end
    end
  end
  assign g_rd    = port_rd[grant];
  assign g_req   = req[grant];
  assign g_wr    = port_wr[grant*WORD_LEN +: WORD_LEN];
  assign sel     = N_PORTS'(1) << grant;
  assign nxt_ptr = (grant == GW'(N_PORTS - 1)) ? '0 : grant + 1'b1;
  assign in_wait = state == WAIT;
  assign done    = in_wait & (mem_rvalid | mem_wvalid | mem_error);
  assign tmo     = in_wait & ~done & (wdog == 16'(TIMEOUT));
  // command mux from the granted port; reads take precedence over writes
  always_comb begin
    mem_rd         = (state == ISSUE) & g_rd;
    mem_wr         = (state == ISSUE && !g_rd) ? g_wr : '0;
    mem_addr       = (state != IDLE) ? port_addr[grant*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    mem_write_data = (state != IDLE) ? port_write_data[grant*DATA_WIDTH +: DATA_WIDTH] : '0;
    port_rvalid    = (in_wait && mem_rvalid) ? sel : '0;
    port_wvalid    = (in_wait && mem_wvalid) ? sel : '0;
    port_error     = ((in_wait && mem_error) || tmo) ? sel : '0;
    port_read_data = (in_wait && mem_rvalid) ? mem_read_data : '0;
  end
  // arbitration FSM, rotating pointer and saturating watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      wdog  <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        grant <= next_idx;
        state <= ISSUE;
      end
    end else if (state == ISSUE) begin
      if (g_req && mem_rdy) begin
        state <= WAIT;
        wdog  <= 16'd1;
      end else if (!g_req) state <= IDLE;
    end else if (state == WAIT) begin
      if (done || tmo) begin
        state <= IDLE;
        ptr   <= nxt_ptr;
        wdog  <= '0;
      end else if (wdog != 16'hFFFF) wdog <= wdog + 16'd1;
    end else state <= IDLE;
  end
endmodule
